attack_check_display: RTL and testbench

Per-player combinational attack validator plus a multiplexed four-digit seven-segment status display, used in each player's board-level top of the two-board Battleship design. The checker compares a player's stored previous attack map with the live switch map. It flags `ok` only when exactly one new position has been added and none removed. The display continuously scans a fixed four-letter word chosen by `word_sel` onto the Basys-style active-low seven-segment digits.

---
 rtl/attack_check_display.sv | 84 ++++++++
 tb/tb_attack_check_display.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/attack_check_display.sv
// rtl/attack_check_display.sv - single-new-attack checker and scanned four-digit word display
module attack_check_display #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] prev_attack,
  input  logic [15:0] new_attack,
  input  logic        word_sel,
  output logic        ok,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  // Active-low segment codes, bit order g..a
  localparam logic [6:0] CH_P = 7'b0001100;
  localparam logic [6:0] CH_L = 7'b1000111;
  localparam logic [6:0] CH_A = 7'b0001000;
  localparam logic [6:0] CH_Y = 7'b0010001;
  localparam logic [6:0] CH_O = 7'b1000000;
  localparam logic [6:0] CH_S = 7'b0010010;
  localparam logic [6:0] CH_E = 7'b0000110;

  logic [15:0]             added;
  logic [15:0]             removed;
  logic [4:0]              add_count;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [REFRESH_BITS-1:0] cnt_d;
  logic [1:0]              digit;
  logic [6:0]              char_code;

  // Valid attack: exactly one cell newly set and no cell cleared; full-width count
  always_comb begin
    added     = new_attack & ~prev_attack;
    removed   = prev_attack & ~new_attack;
    add_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      add_count = add_count + {4'd0, added[i]};
    end
    ok = (add_count == 5'd1) && (removed == 16'h0000);
  end

  // Free-running refresh counter, wraps naturally
  always_comb begin
    cnt_d = cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  end

  // Counter register; reset returns the scan to the rightmost digit immediately
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign digit = cnt_q[REFRESH_BITS-1 -: 2];

  // Anode select and character lookup; digit 3 is the leftmost letter of the word
  always_comb begin
    an        = 4'b1110;
    char_code = 7'b1111111;
    case (digit)
      2'd0: begin
        an        = 4'b1110;
        char_code = word_sel ? CH_E : CH_Y;
      end
      2'd1: begin
        an        = 4'b1101;
        char_code = word_sel ? CH_S : CH_A;
      end
      2'd2: begin
        an        = 4'b1011;
        char_code = word_sel ? CH_O : CH_L;
      end
      default: begin
        an        = 4'b0111;
        char_code = word_sel ? CH_L : CH_P;
      end
    endcase
    seg = {1'b1, char_code};
  end

endmodule

// File: tb/tb_attack_check_display.sv
// tb/tb_attack_check_display.sv - scoreboard bench for attack_check_display at REFRESH_BITS=4
module tb_attack_check_display;

  localparam int RB = 4;

  logic        clk;
  logic        clr_n;
  logic [15:0] prev_attack;
  logic [15:0] new_attack;
  logic        word_sel;
  logic        ok;
  logic [7:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } disp_t;

  logic  ok_q[$];
  disp_t disp_q[$];

  attack_check_display #(.REFRESH_BITS(RB)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .prev_attack(prev_attack),
    .new_attack (new_attack),
    .word_sel   (word_sel),
    .ok         (ok),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_char(input logic ws, input int dig);
    logic [7:0] c;
    case ({ws, dig[1:0]})
      3'b0_11: c = 8'b10001100; // P
      3'b0_10: c = 8'b11000111; // L
      3'b0_01: c = 8'b10001000; // A
      3'b0_00: c = 8'b10010001; // Y
      3'b1_11: c = 8'b11000111; // L
      3'b1_10: c = 8'b11000000; // O
      3'b1_01: c = 8'b10010010; // S
      default: c = 8'b10000110; // E
    endcase
    return c;
  endfunction

  function automatic disp_t model_disp(input int cnt, input logic ws);
    disp_t d;
    int    dig;
    dig   = (cnt >> (RB - 2)) & 3;
    d.an  = ~(4'b0001 << dig);
    d.seg = exp_char(ws, dig);
    return d;
  endfunction

  task automatic push_disp();
    disp_q.push_back(model_disp(model_cnt, word_sel));
  endtask

  task automatic pop_disp(input string name);
    disp_t e;
    e = disp_q.pop_front();
    checks++;
    if (an !== e.an || seg !== e.seg) begin
      errors++;
      $display("FAIL %s cnt=%0d: an=%b seg=%b, expected an=%b seg=%b",
               name, model_cnt, an, seg, e.an, e.seg);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_cnt = (model_cnt + 1) % (1 << RB);
    @(negedge clk);
  endtask

  task automatic apply_attack(input logic [15:0] p, input logic [15:0] n,
                              input logic exp_ok, input string name);
    logic e;
    ok_q.push_back(exp_ok);
    prev_attack = p;
    new_attack  = n;
    #1;
    e = ok_q.pop_front();
    checks++;
    if (ok !== e) begin
      errors++;
      $display("FAIL %s prev=%h new=%h: ok=%b, expected %b", name, p, n, ok, e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    word_sel = 1'b0;
    #2;
    clr_n = 1'b0;
    model_cnt = 0;
    push_disp();
    #1;
    pop_disp("reset_low");
    @(negedge clk);
    push_disp();
    pop_disp("reset_held");
    clr_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      push_disp();
      pop_disp("reset_scan");
    end
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL reset_wrap: an=%b, expected 1110", an);
    end
  endtask

  task automatic test_checker();
    apply_attack(16'h0000, 16'h0010, 1'b1, "sweep_one");
    apply_attack(16'h0000, 16'h0000, 1'b0, "sweep_none");
    apply_attack(16'h0000, 16'h0011, 1'b0, "sweep_two");
    apply_attack(16'h00F0, 16'h01F0, 1'b1, "subset_add");
    apply_attack(16'h00F0, 16'h00F0, 1'b0, "subset_same");
    apply_attack(16'h00F0, 16'h0170, 1'b0, "subset_swap");
    apply_attack(16'hFFFF, 16'hFFFF, 1'b0, "ext_full");
    apply_attack(16'h7FFF, 16'hFFFF, 1'b1, "ext_top_bit");
    apply_attack(16'h0000, 16'hFFFF, 1'b0, "ext_all_new");
    apply_attack(16'hFFFF, 16'h0000, 1'b0, "ext_all_cleared");
    for (int i = 0; i < 20; i++) begin
      logic [15:0] p;
      logic [15:0] n;
      logic        e;
      p = 16'($urandom);
      if (i % 2 == 0) n = p | (16'h1 << $urandom_range(15, 0));
      else            n = 16'($urandom);
      e = ($countones(n & ~p) == 1) && ((p & ~n) == 16'h0);
      apply_attack(p, n, e, "random_attack");
    end
  endtask

  task automatic test_ok_during_reset();
    clr_n = 1'b0;
    apply_attack(16'h0000, 16'h8000, 1'b1, "ok_in_reset");
    @(negedge clk);
    clr_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_word_switch();
    word_sel = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    push_disp();
    pop_disp("digit2_play");
    word_sel = 1'b1;
    push_disp();
    #1;
    pop_disp("digit2_lose");
    checks++;
    if (an !== 4'b1011 || seg !== 8'b11000000) begin
      errors++;
      $display("FAIL word_switch: an=%b seg=%b, expected an=1011 seg=11000000", an, seg);
    end
    word_sel = 1'b0;
  endtask

  task automatic test_midscan_reset();
    for (int i = 0; i < 5; i++) tick();
    #3;
    clr_n = 1'b0;
    model_cnt = 0;
    push_disp();
    #1;
    pop_disp("midscan_reset");
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_one_hot();
    int bad;
    bad = 0;
    for (int i = 0; i < 3 * (1 << RB); i++) begin
      tick();
      word_sel = 1'($urandom);
      push_disp();
      #1;
      pop_disp("frame_scan");
      if ($countones(~an) != 1 || seg[7] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL one_hot: %0d bad cycles, expected 0", bad);
    end
  endtask

  initial begin
    clr_n       = 1'b0;
    prev_attack = 16'h0;
    new_attack  = 16'h0;
    word_sel    = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    test_reset();
    test_checker();
    test_ok_during_reset();
    test_word_switch();
    test_midscan_reset();
    test_one_hot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
